board_cursor_ctrl: RTL

//  Parametrised cursor-to-board mapper and click-driven move selector. Maps mouse pixel coordinates
//  to a board square and flags off-board positions. Debounces LMB and runs a pick/place FSM that

---
 rtl/vga_pkg.sv | 9 +
 rtl/btn_debounce.sv | 55 +++++
 rtl/board_cursor_ctrl.sv | 112 +++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA/board definitions: board geometry defaults and the move-selector state type.
package vga_pkg;
  localparam int DEF_BOARD_X0 = 256;
  localparam int DEF_BOARD_Y0 = 128;
  localparam int DEF_SQ_LOG2  = 6;
  localparam int DEF_BOARD_N  = 8;

  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, MOVE = 2'd2} board_sel_t;
endpackage

// File: rtl/btn_debounce.sv
// Button debouncer: a new raw level is accepted after DEBOUNCE_CYC consecutive cycles;
// rise/fall pulse for one cycle together with the accepted level change.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);
  generate
    if (DEBOUNCE_CYC == 0) begin : g_nodb
      always_ff @(posedge clk) begin
        if (rst) begin
          level <= 1'b0;
          rise  <= 1'b0;
          fall  <= 1'b0;
        end else begin
          level <= raw;
          rise  <= raw & ~level;
          fall  <= ~raw & level;
        end
      end
    end else begin : g_db
      localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
      localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYC - 1);
      logic [CW-1:0] cnt;

      always_ff @(posedge clk) begin
        if (rst) begin
          level <= 1'b0;
          rise  <= 1'b0;
          fall  <= 1'b0;
          cnt   <= '0;
        end else begin
          rise <= 1'b0;
          fall <= 1'b0;
          // any cycle back at the accepted level restarts the stability count
          if (raw == level) begin
            cnt <= '0;
          end else if (cnt == LAST) begin
            level <= raw;
            rise  <= raw;
            fall  <= ~raw;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      end
    end
  endgenerate
endmodule

// File: rtl/board_cursor_ctrl.sv
// Cursor-to-square mapper plus click-driven pick/place move selector.
// Optional CANCEL_RMB_EN: debounced RMB press cancels a held piece.
module board_cursor_ctrl
  import vga_pkg::*;
#(
  parameter  int BOARD_X0     = DEF_BOARD_X0,
  parameter  int BOARD_Y0     = DEF_BOARD_Y0,
  parameter  int SQ_LOG2      = DEF_SQ_LOG2,
  parameter  int BOARD_N      = DEF_BOARD_N,
  parameter  int DEBOUNCE_CYC = 4,
  localparam int IDX_W        = $clog2(BOARD_N),
  localparam int SQ_W         = 2 * IDX_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            lmb,
  input  logic            rmb,
  input  logic [11:0]     mouse_xpos,
  input  logic [11:0]     mouse_ypos,
  output logic [SQ_W-1:0] square,
  output logic            in_board,
  output logic            piece_held,
  output logic [SQ_W-1:0] src_square,
  output logic [SQ_W-1:0] dst_square,
  output logic            move_valid,
  input  logic            move_ready
);
  localparam logic [12:0] SPAN = 13'(BOARD_N << SQ_LOG2);

  logic [12:0] dx, dy;
  logic        inb_n;

  // bit 12 is the sign of the 13-bit difference
  assign dx    = {1'b0, mouse_xpos} - 13'(BOARD_X0);
  assign dy    = {1'b0, mouse_ypos} - 13'(BOARD_Y0);
  assign inb_n = ~dx[12] && (dx < SPAN) && ~dy[12] && (dy < SPAN);

  always_ff @(posedge clk) begin
    if (rst) begin
      square   <= '0;
      in_board <= 1'b0;
    end else begin
      in_board <= inb_n;
      if (inb_n) square <= {dy[SQ_LOG2 +: IDX_W], dx[SQ_LOG2 +: IDX_W]};
    end
  end

  logic click, lmb_level_unused, lmb_rise_unused;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_lmb (
    .clk(clk), .rst(rst), .raw(lmb),
    .level(lmb_level_unused), .rise(lmb_rise_unused), .fall(click)
  );

  logic cancel;
`ifdef CANCEL_RMB_EN
  logic rmb_level_unused, rmb_fall_unused;
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_rmb (
    .clk(clk), .rst(rst), .raw(rmb),
    .level(rmb_level_unused), .rise(cancel), .fall(rmb_fall_unused)
  );
`else
  logic rmb_unused;
  assign rmb_unused = rmb;
  assign cancel     = 1'b0;
`endif

  board_sel_t      state, state_n;
  logic [SQ_W-1:0] src_n, dst_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      src_square <= '0;
      dst_square <= '0;
    end else begin
      state      <= state_n;
      src_square <= src_n;
      dst_square <= dst_n;
    end
  end

  always_comb begin
    state_n = state;
    src_n   = src_square;
    dst_n   = dst_square;
    unique case (state)
      IDLE: if (click && in_board) begin
        src_n   = square;
        state_n = HOLD;
      end
      HOLD: begin
        // cancel has priority over a coincident click
        if (cancel) begin
          state_n = IDLE;
        end else if (click && in_board) begin
          if (square == src_square) begin
            state_n = IDLE;
          end else begin
            dst_n   = square;
            state_n = MOVE;
          end
        end
      end
      MOVE: if (move_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign piece_held = (state == HOLD);
  assign move_valid = (state == MOVE);
endmodule
